// File: rtl/mem_inst_param.sv
// rtl/mem_inst_param.sv - instruction memory with burst loader and faulting fetch port
module mem_inst_param #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 14,
    parameter bit                BYTE_ADDR = 1'b0,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic              clock_auto,
    input  logic              reset,
    input  logic [31:0]       endereco,
    input  logic              leitura_en,
    output logic [DATA_W-1:0] saida,
    output logic              saida_valida,
    output logic              erro_end,
    input  logic              carga_inicio,
    input  logic [31:0]       carga_base,
    input  logic [DATA_W-1:0] carga_dado,
    input  logic              carga_valida,
    output logic              carga_pronta,
    input  logic              carga_fim,
    output logic              ocupada,
    output logic [ADDR_W:0]   palavras_carregadas
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    typedef enum logic {OCIOSO, CARGA} estado_t;

    estado_t             state_q, state_d;
    logic [ADDR_W-1:0]   pointer_q;
    logic [ADDR_W:0]     count_q;
    logic                wr_en;
    logic                load_start;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic [31:0] to_index(input logic [31:0] a);
        return BYTE_ADDR ? {2'b00, a[31:2]} : a;
    endfunction

    logic [31:0] fetch_idx;
    logic [31:0] base_idx;
    logic        fetch_fault;
    logic        base_ok;
    logic        fetch_accept;

    always_comb begin
        fetch_idx    = to_index(endereco);
        base_idx     = to_index(carga_base);
        fetch_fault  = (|fetch_idx[31:ADDR_W]) || (BYTE_ADDR && (endereco[1:0] != 2'b00));
        base_ok      = ~(|base_idx[31:ADDR_W]);
        fetch_accept = leitura_en && (state_q == OCIOSO);
    end

    always_comb begin
        state_d    = state_q;
        wr_en      = 1'b0;
        load_start = 1'b0;
        case (state_q)
            OCIOSO: begin
                if (carga_inicio && base_ok) begin
                    state_d    = CARGA;
                    load_start = 1'b1;
                end
            end
            CARGA: begin
                // The last index ends the burst so the pointer never wraps.
                if (carga_valida) begin
                    wr_en = 1'b1;
                    if (carga_fim || (pointer_q == {ADDR_W{1'b1}}))
                        state_d = OCIOSO;
                end else if (carga_fim) begin
                    state_d = OCIOSO;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock_auto) begin
        if (reset) begin
            state_q   <= OCIOSO;
            pointer_q <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_start) begin
                pointer_q <= base_idx[ADDR_W-1:0];
                count_q   <= '0;
            end else if (wr_en) begin
                pointer_q <= pointer_q + PTR_ONE;
                count_q   <= count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock_auto) begin
        if (wr_en && !reset)
            mem[pointer_q] <= carga_dado;
    end

    always_ff @(posedge clock_auto) begin
        if (reset) begin
            saida        <= '0;
            saida_valida <= 1'b0;
            erro_end     <= 1'b0;
        end else begin
            saida_valida <= fetch_accept;
            erro_end     <= fetch_accept && fetch_fault;
            if (fetch_accept)
                saida <= fetch_fault ? NOP_WORD : mem[fetch_idx[ADDR_W-1:0]];
        end
    end

    assign carga_pronta        = (state_q == CARGA);
    assign ocupada             = (state_q == CARGA);
    assign palavras_carregadas = count_q;

endmodule
